dmem_load_store_unit: RTL and testbench

- Initiator side of the data-memory interface.
- Accepts one load/store request at a time from the core's MEM stage and sequences the single-port, word-wide data memory (MemRead/MemWrite, word address, write data, read data).
- Implements RV32I LB/LH/LW/LBU/LHU/SB/SH/SW:
  - byte-lane extraction with sign/zero extension for loads;
  - read-modify-write for sub-word stores, because the memory writes whole words only.
- Reports misaligned and out-of-range accesses as errors without touching memory.

---
 rtl/dmem_lsu_pkg.sv | 32 +++
 rtl/dmem_lane_align.sv | 49 ++++
 rtl/dmem_load_store_unit.sv | 138 +++++++++++++
 tb/tb_dmem_load_store_unit.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: RV32I funct3 codes,
// sequencer states and the access-alignment rule.
package dmem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE_W,
    RMW_RD,
    RMW_WR,
    DONE
  } lsu_state_t;

  // Halves need an even byte address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    logic mis;
    mis = 1'b0;
    case (funct3)
      F3_H, F3_HU: mis = offset[0];
      F3_W:        mis = |offset;
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between the word-wide memory and the core: extract/extend
// for loads, byte/half merge into a previously read word for sub-word stores.
module dmem_lane_align
  import dmem_lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] load_word_i,
  input  logic [31:0] merge_word_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merge_data_o
);

  logic [7:0]  word_bytes [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign word_bytes[gi] = load_word_i[8*gi +: 8];
  end

  assign byte_sel = word_bytes[offset_i];
  assign half_sel = offset_i[1] ? load_word_i[31:16] : load_word_i[15:0];

  always_comb begin
    load_data_o = load_word_i;
    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data_o = {24'd0, byte_sel};
      F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data_o = {16'd0, half_sel};
      default: load_data_o = load_word_i;
    endcase
  end

  always_comb begin
    merge_data_o = merge_word_i;
    case (funct3_i[1:0])
      2'b00: merge_data_o[8*offset_i +: 8] = store_data_i[7:0];
      2'b01: begin
        if (offset_i[1]) merge_data_o[31:16] = store_data_i[15:0];
        else             merge_data_o[15:0]  = store_data_i[15:0];
      end
      default: merge_data_o = store_data_i;
    endcase
  end

endmodule

// File: rtl/dmem_load_store_unit.sv
// Single-outstanding RV32I load/store sequencer for a word-wide, single-port data
// memory; sub-word stores are done as read-modify-write.
module dmem_load_store_unit
  import dmem_lsu_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MEM_AW    = 13,
  parameter int MEM_DEPTH = 4198
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  lsu_state_t          state_q, state_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [MEM_AW+1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   merge_q, merge_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                illegal_f3;
  logic                out_of_range;
  logic                req_err;
  logic [DATA_W-1:0]   load_data;
  logic [DATA_W-1:0]   merge_data;

  assign illegal_f3   = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                        (req_we && req_funct3[2]);
  assign out_of_range = ({2'b00, req_addr[31:2]} >= 32'(MEM_DEPTH));
  assign req_err      = illegal_f3 || is_misaligned(req_funct3, req_addr[1:0]) || out_of_range;

  dmem_lane_align u_align (
    .funct3_i     (funct3_q),
    .offset_i     (addr_q[1:0]),
    .load_word_i  (mem_rd),
    .merge_word_i (merge_q),
    .store_data_i (wdata_q),
    .load_data_o  (load_data),
    .merge_data_o (merge_data)
  );

  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merge_d  = merge_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          funct3_d = req_funct3;
          addr_d   = req_addr[MEM_AW+1:0];
          wdata_d  = req_wdata;
          err_d    = req_err;
          if (req_err) begin
            rdata_d = '0;
            state_d = DONE;
          end else if (!req_we) begin
            state_d = LOAD;
          end else if (req_funct3[1:0] == 2'b10) begin
            state_d = STORE_W;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      LOAD: begin
        rdata_d = load_data;
        state_d = DONE;
      end
      STORE_W: begin
        rdata_d = '0;
        state_d = DONE;
      end
      RMW_RD: begin
        merge_d = mem_rd;
        state_d = RMW_WR;
      end
      RMW_WR: begin
        rdata_d = '0;
        state_d = DONE;
      end
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merge_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merge_q  <= merge_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Memory strobes come straight from the state so reset drops them at once.
  assign req_ready  = (state_q == IDLE);
  assign mem_read   = (state_q == LOAD) || (state_q == RMW_RD);
  assign mem_write  = (state_q == STORE_W) || (state_q == RMW_WR);
  assign mem_addr   = addr_q[MEM_AW+1:2];
  assign mem_wd     = (state_q == RMW_WR) ? merge_data : wdata_q;
  assign resp_valid = (state_q == DONE);
  assign resp_err   = (state_q == DONE) && err_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_load_store_unit.sv
// Self-checking bench for dmem_load_store_unit: directed vector table, reset abort,
// back-to-back requests and randomized traffic against a behavioural memory model.
module tb_dmem_load_store_unit;

  localparam int MEM_DEPTH = 4198;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [12:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem     [0:8191];
  logic [31:0] ref_mem [0:8191];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_load_store_unit #(.DATA_W(32), .MEM_AW(13), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  // Word-wide memory with combinational read and clocked write.
  assign mem_rd = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wd;
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference behaviour derived from the RV32I rules with plain arithmetic.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] erd, output logic eerr,
                       output int elat, output int enrd, output int enwr);
    int unsigned f, widx, off, nbytes;
    longint unsigned span, field, word, mask;
    f      = 32'(f3);
    widx   = addr / 4;
    off    = addr % 4;
    nbytes = (f % 4 == 0) ? 1 : (f % 4 == 1) ? 2 : 4;
    erd    = '0;
    elat   = 1;
    enrd   = 0;
    enwr   = 0;
    eerr   = (f == 3) || (f == 6) || (f == 7) || (we && f >= 4);
    if (!eerr) eerr = ((addr % nbytes) != 0) || (widx >= MEM_DEPTH);
    if (eerr) return;
    word = 64'(ref_mem[widx]);
    span = 64'd1 << (8 * nbytes);
    if (!we) begin
      field = (word >> (8 * off)) % span;
      if (f < 4 && nbytes < 4 && field >= span / 2) field = field - span;
      erd  = field[31:0];
      elat = 2;
      enrd = 1;
    end else begin
      mask = (span - 1) << (8 * off);
      word = (word & ~mask) | ((64'(wd) << (8 * off)) & mask);
      ref_mem[widx] = word[31:0];
      elat = (nbytes == 4) ? 2 : 3;
      enrd = (nbytes == 4) ? 0 : 1;
      enwr = 1;
    end
  endtask

  // One transaction; lat is the index of the cycle after acceptance showing resp_valid.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic err,
                        output int lat, output int nrd, output int nwr,
                        output int bad_addr, output int overlap);
    rd = '0; err = 1'b0; lat = 0; nrd = 0; nwr = 0; bad_addr = 0; overlap = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    for (int w = 0; w < 20 && !req_ready; w++) @(negedge clk);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_read) nrd++;
      if (mem_write) nwr++;
      if (mem_read && mem_write) overlap++;
      if ((mem_read || mem_write) && mem_addr != addr[14:2]) bad_addr++;
      if (resp_valid) begin
        lat = k;
        rd  = resp_rdata;
        err = resp_err;
        break;
      end
    end
    @(posedge clk);
  endtask

  task automatic run_and_check(input string tag, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    logic [31:0] m_rd, g_rd;
    logic        m_err, g_err;
    int          m_lat, m_nrd, m_nwr, g_lat, g_nrd, g_nwr, g_bad, g_ovl;
    model(we, f3, addr, wd, m_rd, m_err, m_lat, m_nrd, m_nwr);
    do_req(we, f3, addr, wd, g_rd, g_err, g_lat, g_nrd, g_nwr, g_bad, g_ovl);
    $display("%s: we=%0d f3=%0d addr=0x%08h wd=0x%08h -> rdata=0x%08h err=%0d lat=%0d rd=%0d wr=%0d",
             tag, we, f3, addr, wd, g_rd, g_err, g_lat, g_nrd, g_nwr);
    check({tag, " rdata"}, g_rd, exp_rd);
    check({tag, " err"}, 32'(g_err), 32'(exp_err));
    check({tag, " latency"}, 32'(g_lat), 32'(exp_lat));
    check({tag, " mem_read cycles"}, 32'(g_nrd), 32'(m_nrd));
    check({tag, " mem_write cycles"}, 32'(g_nwr), 32'(m_nwr));
    check({tag, " mem_addr wrong"}, 32'(g_bad), 32'd0);
    check({tag, " read+write overlap"}, 32'(g_ovl), 32'd0);
    if (we && !m_err)
      check({tag, " stored word"}, mem[addr[14:2]], ref_mem[addr[14:2]]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e_rd;
    logic        e_err;
    int          e_lat, e_nrd, e_nwr;
    logic [31:0] b_addr [3];
    logic [2:0]  b_f3   [3];
    logic [31:0] b_exp  [3];
    logic [31:0] b_got  [3];
    int          n_acc, n_resp, ready_bad, seen;
    logic        busy, acc, fin;
    logic [31:0] saved;

    for (int i = 0; i < 8192; i++) begin
      mem[i]     = (32'(i) * 32'h9E3779B9) ^ 32'h5A5A5A5A;
      ref_mem[i] = (32'(i) * 32'h9E3779B9) ^ 32'h5A5A5A5A;
    end

    // Directed vectors: expectations are the architectural results.
    vq.push_back('{1'b1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h00000000, 1'b0, 2});
    vq.push_back('{1'b0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0, 2});
    vq.push_back('{1'b0, 3'b000, 32'h13,   32'h0,        32'hFFFFFFDE, 1'b0, 2});
    vq.push_back('{1'b0, 3'b100, 32'h13,   32'h0,        32'h000000DE, 1'b0, 2});
    vq.push_back('{1'b0, 3'b001, 32'h10,   32'h0,        32'hFFFFBEEF, 1'b0, 2});
    vq.push_back('{1'b0, 3'b101, 32'h12,   32'h0,        32'h0000DEAD, 1'b0, 2});
    vq.push_back('{1'b1, 3'b000, 32'h11,   32'h12345677, 32'h00000000, 1'b0, 3});
    vq.push_back('{1'b0, 3'b010, 32'h10,   32'h0,        32'hDEAD77EF, 1'b0, 2});
    vq.push_back('{1'b1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h00000000, 1'b0, 2});
    vq.push_back('{1'b1, 3'b001, 32'h12,   32'h000000AA, 32'h00000000, 1'b0, 3});
    vq.push_back('{1'b0, 3'b010, 32'h10,   32'h0,        32'h00AABEEF, 1'b0, 2});
    vq.push_back('{1'b0, 3'b010, 32'h21,   32'h0,        32'h00000000, 1'b1, 1});
    vq.push_back('{1'b0, 3'b000, 32'h11,   32'h0,        32'hFFFFFFBE, 1'b0, 2});
    vq.push_back('{1'b0, 3'b001, 32'h03,   32'h0,        32'h00000000, 1'b1, 1});
    vq.push_back('{1'b1, 3'b010, 32'h4198, 32'h11111111, 32'h00000000, 1'b1, 1});
    vq.push_back('{1'b1, 3'b010, 32'h4194, 32'hCAFEF00D, 32'h00000000, 1'b0, 2});
    vq.push_back('{1'b0, 3'b010, 32'h4194, 32'h0,        32'hCAFEF00D, 1'b0, 2});
    vq.push_back('{1'b0, 3'b011, 32'h10,   32'h0,        32'h00000000, 1'b1, 1});
    vq.push_back('{1'b1, 3'b100, 32'h10,   32'h0,        32'h00000000, 1'b1, 1});
    vq.push_back('{1'b0, 3'b101, 32'h13,   32'h0,        32'h00000000, 1'b1, 1});
    vq.push_back('{1'b0, 3'b110, 32'h10,   32'h0,        32'h00000000, 1'b1, 1});

    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    $display("reset: ready=%0d valid=%0d err=%0d rd=%0d wr=%0d rdata=0x%08h",
             req_ready, resp_valid, resp_err, mem_read, mem_write, resp_rdata);
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset resp_err", 32'(resp_err), 32'd0);
    check("reset mem_read", 32'(mem_read), 32'd0);
    check("reset mem_write", 32'(mem_write), 32'd0);
    check("reset resp_rdata", resp_rdata, 32'd0);
    rst = 1'b1;

    // Reset while the sub-word store is in its write cycle must abandon it.
    saved = ref_mem[5];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h14; req_wdata = 32'hA5;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort mem_write before reset", 32'(mem_write), 32'd1);
    rst = 1'b0;
    #1;
    check("abort mem_write after reset", 32'(mem_write), 32'd0);
    check("abort mem_read after reset", 32'(mem_read), 32'd0);
    check("abort req_ready in reset", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    $display("abort: word5=0x%08h resp_pulses=%0d ready=%0d", mem[5], seen, req_ready);
    check("abort resp_valid pulses", 32'(seen), 32'd0);
    check("abort word unchanged", mem[5], saved);
    check("abort req_ready after", 32'(req_ready), 32'd1);

    foreach (vq[i])
      run_and_check($sformatf("vec%0d", i), vq[i].we, vq[i].f3, vq[i].addr, vq[i].wd,
                    vq[i].rd, vq[i].err, vq[i].lat);

    // Back-to-back: req_valid held high across three loads.
    b_addr[0] = 32'h10; b_f3[0] = 3'b010;
    b_addr[1] = 32'h12; b_f3[1] = 3'b101;
    b_addr[2] = 32'h10; b_f3[2] = 3'b000;
    for (int i = 0; i < 3; i++) begin
      model(1'b0, b_f3[i], b_addr[i], 32'h0, b_exp[i], e_err, e_lat, e_nrd, e_nwr);
      b_got[i] = '0;
    end
    n_acc = 0; n_resp = 0; ready_bad = 0; busy = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = b_f3[0]; req_addr = b_addr[0]; req_wdata = '0;
    for (int c = 0; c < 40 && n_resp < 3; c++) begin
      if (c != 0) @(negedge clk);
      if (req_ready == busy) ready_bad++;
      fin = resp_valid;
      if (resp_valid) begin
        b_got[n_resp] = resp_rdata;
        n_resp++;
      end
      acc = req_ready && req_valid;
      @(posedge clk);
      if (acc) begin
        busy = 1'b1;
        n_acc++;
      end
      if (fin) busy = 1'b0;
      #1;
      if (acc) begin
        if (n_acc < 3) begin
          req_funct3 = b_f3[n_acc];
          req_addr   = b_addr[n_acc];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++)
      $display("b2b%0d: addr=0x%08h f3=%0d -> rdata=0x%08h", i, b_addr[i], b_f3[i], b_got[i]);
    check("b2b accepted", 32'(n_acc), 32'd3);
    check("b2b responses", 32'(n_resp), 32'd3);
    check("b2b ready while busy", 32'(ready_bad), 32'd0);
    for (int i = 0; i < 3; i++)
      check($sformatf("b2b rdata%0d", i), b_got[i], b_exp[i]);
    @(negedge clk);

    // Randomized traffic against the behavioural model.
    for (int t = 0; t < 150; t++) begin
      logic        r_we;
      logic [2:0]  r_f3;
      logic [31:0] r_addr, r_wd;
      int          sel;
      r_we = 1'($urandom_range(0, 1));
      r_f3 = 3'($urandom_range(0, 7));
      r_wd = $urandom;
      sel  = int'($urandom_range(0, 9));
      if (sel < 7)      r_addr = 32'($urandom_range(0, 63));
      else if (sel < 9) r_addr = 32'(4196 * 4) + 32'($urandom_range(0, 15));
      else              r_addr = $urandom;
      begin
        logic [31:0] x_rd;
        logic        x_err;
        int          x_lat, x_nrd, x_nwr;
        logic [31:0] snap [0:8191];
        // Dry-run the model on a snapshot to get expectations; run_and_check reapplies it.
        snap = ref_mem;
        model(r_we, r_f3, r_addr, r_wd, x_rd, x_err, x_lat, x_nrd, x_nwr);
        ref_mem = snap;
        run_and_check($sformatf("rnd%0d", t), r_we, r_f3, r_addr, r_wd, x_rd, x_err, x_lat);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
